// File: rtl/i2s_lock_mute.sv
// LRCK framing qualifier: checks LRCK half-period length against BCK, tracks lock, and mutes DATA while framing is untrusted.
// Optional FRAME_ALIGN_UNMUTE_EN: release mute only on an LRCK fall, so the first unmuted bit is a left-word MSB.
module i2s_lock_mute #(
  parameter int unsigned HALF_BCK    = 32,
  parameter int unsigned LOCK_FRAMES = 8
) (
  input  logic       BCK,
  input  logic       RST,
  input  logic       LRCK,
  input  logic       DATAIN,
  output logic       LRCKOUT,
  output logic       DATAOUT,
  output logic       LOCKED,
  output logic       MUTE,
  output logic [7:0] ERRCNT
);

  localparam int unsigned HW          = $clog2(HALF_BCK + 1);
  localparam int unsigned GOOD_TARGET = 2 * LOCK_FRAMES;
  localparam int unsigned GW          = $clog2(GOOD_TARGET + 1);
  localparam int unsigned EW          = 8;

  localparam logic [HW-1:0] HCNT_LAST = HW'(HALF_BCK - 1);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(HALF_BCK);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_TARGET - 1);
  localparam logic [EW-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            lrck_d;
  logic [HW-1:0]   hcnt;
  logic [HW-1:0]   hcnt_nxt;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_cnt_nxt;
  logic [EW-1:0]   errcnt_nxt;
  logic            mute_nxt;

  logic            lrck_edge;
  logic            good_edge;
  logic            sat_edge;
  logic            short_err;
  logic            tmo_err;

  // LRCK event decode relative to the half-period counter
  assign lrck_edge = (LRCK != lrck_d);
  assign good_edge = lrck_edge && (hcnt == HCNT_LAST);
  assign sat_edge  = lrck_edge && (hcnt == HCNT_SAT);
  assign short_err = lrck_edge && (hcnt < HCNT_LAST) && (state != ST_UNLOCKED);
  // Fires only on the step into saturation, so a long stall counts once
  assign tmo_err   = !lrck_edge && (hcnt == HCNT_LAST) && (state != ST_UNLOCKED);

`ifdef FRAME_ALIGN_UNMUTE_EN
  logic lrck_fall;
  assign lrck_fall = lrck_d & ~LRCK;
`endif

  always_ff @(posedge BCK) begin
    if (RST) begin
      state <= ST_UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    errcnt_nxt   = ERRCNT;
    mute_nxt     = MUTE;
    hcnt_nxt     = hcnt;

    if (lrck_edge) begin
      hcnt_nxt = '0;
    end else if (hcnt != HCNT_SAT) begin
      hcnt_nxt = hcnt + HW'(1);
    end

    if ((short_err || tmo_err) && (ERRCNT != ERR_MAX)) begin
      errcnt_nxt = ERRCNT + EW'(1);
    end

    unique case (state)
      ST_UNLOCKED: begin
        if (lrck_edge) begin
          state_nxt    = ST_ACQUIRE;
          good_cnt_nxt = '0;
        end
      end
      ST_ACQUIRE: begin
        if (short_err) begin
          good_cnt_nxt = '0;
        end else if (tmo_err) begin
          state_nxt = ST_UNLOCKED;
        end else if (good_edge) begin
          good_cnt_nxt = good_cnt + GW'(1);
          if (good_cnt == GOOD_LAST) begin
            state_nxt = ST_LOCKED;
          end
        end else if (sat_edge) begin
          good_cnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (short_err || sat_edge) begin
          state_nxt    = ST_ACQUIRE;
          good_cnt_nxt = '0;
        end else if (tmo_err) begin
          state_nxt = ST_UNLOCKED;
        end
      end
      default: begin
        state_nxt    = ST_UNLOCKED;
        good_cnt_nxt = '0;
      end
    endcase

`ifdef FRAME_ALIGN_UNMUTE_EN
    // Mute on any exit from lock; unmute only on an LRCK fall while already locked
    if (state_nxt != ST_LOCKED) begin
      mute_nxt = 1'b1;
    end else if ((state == ST_LOCKED) && lrck_fall) begin
      mute_nxt = 1'b0;
    end
`else
    mute_nxt = (state_nxt != ST_LOCKED);
`endif
  end

  // Counters, status and the 1-BCK forwarding path
  always_ff @(posedge BCK) begin
    if (RST) begin
      lrck_d   <= 1'b0;
      hcnt     <= '0;
      good_cnt <= '0;
      LRCKOUT  <= 1'b0;
      DATAOUT  <= 1'b0;
      LOCKED   <= 1'b0;
      MUTE     <= 1'b1;
      ERRCNT   <= '0;
    end else begin
      lrck_d   <= LRCK;
      hcnt     <= hcnt_nxt;
      good_cnt <= good_cnt_nxt;
      LRCKOUT  <= LRCK;
      DATAOUT  <= MUTE ? 1'b0 : DATAIN;
      LOCKED   <= (state_nxt == ST_LOCKED);
      MUTE     <= mute_nxt;
      ERRCNT   <= errcnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_lock_mute.sv
// Randomized bench for i2s_lock_mute: edge-distance reference model checked every cycle, plus literal pins.
module tb_i2s_lock_mute;

  localparam int H     = 32;
  localparam int LOCKF = 8;
`ifdef FRAME_ALIGN_UNMUTE_EN
  localparam bit MACRO = 1'b1;
`else
  localparam bit MACRO = 1'b0;
`endif

  logic       BCK = 1'b0;
  logic       RST = 1'b1;
  logic       LRCK = 1'b0;
  logic       DATAIN = 1'b0;
  logic       LRCKOUT;
  logic       DATAOUT;
  logic       LOCKED;
  logic       MUTE;
  logic [7:0] ERRCNT;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  i2s_lock_mute #(.HALF_BCK(H), .LOCK_FRAMES(LOCKF)) dut (
    .BCK(BCK), .RST(RST), .LRCK(LRCK), .DATAIN(DATAIN),
    .LRCKOUT(LRCKOUT), .DATAOUT(DATAOUT), .LOCKED(LOCKED),
    .MUTE(MUTE), .ERRCNT(ERRCNT)
  );

  always #5 BCK = ~BCK;

  // Reference model: mode 0 = unlocked, 1 = acquiring, 2 = locked.
  // m_dist is the number of BCK cycles since the last LRCK transition.
  int         m_st;
  int         m_good;
  int         m_dist;
  bit         m_lrck;
  logic       e_lrck, e_data, e_locked, e_mute;
  logic [7:0] e_err;

  always @(posedge BCK) begin
    bit ed, fl, is_err;
    int nst;
    if (RST) begin
      m_st = 0; m_good = 0; m_dist = 1; m_lrck = 1'b0;
      e_lrck = 1'b0; e_data = 1'b0; e_locked = 1'b0; e_mute = 1'b1; e_err = 8'd0;
    end else begin
      ed     = (LRCK != m_lrck);
      fl     = m_lrck && !LRCK;
      nst    = m_st;
      is_err = 1'b0;
      e_data = e_mute ? 1'b0 : DATAIN;
      e_lrck = LRCK;
      if (ed && m_dist < H && m_st != 0) begin
        is_err = 1'b1; nst = 1; m_good = 0;
      end else if (!ed && m_dist == H && m_st != 0) begin
        is_err = 1'b1; nst = 0;
      end else if (ed) begin
        if (m_st == 0) begin
          nst = 1; m_good = 0;
        end else if (m_st == 1) begin
          if (m_dist == H) begin
            m_good = m_good + 1;
            if (m_good == 2 * LOCKF) nst = 2;
          end else begin
            m_good = 0;
          end
        end else if (m_dist > H) begin
          nst = 1; m_good = 0;
        end
      end
      if (is_err && e_err != 8'd255) e_err = e_err + 8'd1;
      if (MACRO) begin
        if (nst != 2) e_mute = 1'b1;
        else if (m_st == 2 && fl) e_mute = 1'b0;
      end else begin
        e_mute = (nst != 2);
      end
      e_locked = (nst == 2);
      m_dist   = ed ? 1 : (m_dist < 100000 ? m_dist + 1 : m_dist);
      m_lrck   = LRCK;
      m_st     = nst;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge BCK) begin
    if (chk_en) begin
      chk("lrckout", 8'(LRCKOUT), 8'(e_lrck));
      chk("dataout", 8'(DATAOUT), 8'(e_data));
      chk("locked",  8'(LOCKED),  8'(e_locked));
      chk("mute",    8'(MUTE),    8'(e_mute));
      chk("errcnt",  ERRCNT,      e_err);
    end
  end

  task automatic cyc(input logic l, input logic d);
    LRCK   = l;
    DATAIN = d;
    @(posedge BCK);
    #1;
  endtask

  task automatic tog();
    cyc(~LRCK, 1'($urandom));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(LRCK, 1'($urandom));
  endtask

  task automatic half(input int n);
    tog();
    hold(n - 1);
  endtask

  task automatic pin_reset(input string tag);
    chk({tag, "_locked"},  8'(LOCKED),  8'd0);
    chk({tag, "_mute"},    8'(MUTE),    8'd1);
    chk({tag, "_dataout"}, 8'(DATAOUT), 8'd0);
    chk({tag, "_lrckout"}, 8'(LRCKOUT), 8'd0);
    chk({tag, "_errcnt"},  ERRCNT,      8'd0);
  endtask

  initial begin
    int r;
    RST = 1'b1;
    cyc(1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b1);
    pin_reset("reset");
    RST = 1'b0;

    // Clean acquisition: lock on the cycle after the 17th edge
    repeat (16) half(H);
    chk("prelock_locked", 8'(LOCKED), 8'd0);
    tog();
    chk("lock_locked", 8'(LOCKED), 8'd1);
    chk("lock_mute", 8'(MUTE), MACRO ? 8'd1 : 8'd0);
    hold(H - 1);
    chk("prefall_mute", 8'(MUTE), MACRO ? 8'd1 : 8'd0);
    cyc(1'b0, 1'($urandom));
    chk("fall_mute", 8'(MUTE), 8'd0);
    cyc(1'b0, 1'b1);
    chk("msb_unmuted", 8'(DATAOUT), 8'd1);
    hold(H - 2);
    repeat (4) half(H);

    // One short half while locked, then relock after 16 good edges
    half(H - 1);
    tog();
    chk("short_locked", 8'(LOCKED), 8'd0);
    chk("short_mute", 8'(MUTE), 8'd1);
    chk("short_errcnt", ERRCNT, 8'd1);
    hold(H - 1);
    repeat (15) half(H);
    chk("relock_pre", 8'(LOCKED), 8'd0);
    tog();
    chk("relock", 8'(LOCKED), 8'd1);
    hold(H - 1);

    // LRCK stuck high for 200 BCK while locked
    if (LRCK == 1'b1) half(H);
    tog();
    hold(H - 1);
    chk("stall_pre_locked", 8'(LOCKED), 8'd1);
    chk("stall_pre_errcnt", ERRCNT, 8'd1);
    hold(1);
    chk("stall_locked", 8'(LOCKED), 8'd0);
    chk("stall_errcnt", ERRCNT, 8'd2);
    hold(200 - H - 1);
    chk("stall_once", ERRCNT, 8'd2);

    // Resume: acquisition starts at the first edge
    repeat (16) half(H);
    chk("resume_pre", 8'(LOCKED), 8'd0);
    tog();
    chk("resume_lock", 8'(LOCKED), 8'd1);
    hold(5);

    // Reset mid-frame while locked
    RST = 1'b1;
    cyc(1'b0, 1'b1);
    pin_reset("midreset");
    RST = 1'b0;

    // Randomized framing disturbances interleaved with clean runs
    for (int k = 0; k < 12; k++) begin
      repeat (18) half(H);
      for (int j = 0; j < 5; j++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)       half(H);
        else if (r == 6) half(H - 1);
        else if (r == 7) half(H + 1);
        else if (r == 8) half(int'($urandom_range(2, 40)));
        else             half(10);
      end
    end

    // Sustained garbage framing saturates the error counter
    repeat (300) half(10);
    chk("sat_errcnt", ERRCNT, 8'd255);
    chk("sat_locked", 8'(LOCKED), 8'd0);
    chk("sat_dataout", 8'(DATAOUT), 8'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
